// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the transmit packet arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GNT0, GNT1)
//   PKT_DATA_W  : width of the xge_mac packet data bus
//   PKT_MOD_W   : width of the end-of-frame byte-count field
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int PKT_DATA_W = 64;
  localparam int PKT_MOD_W  = 3;

endpackage

// File: rtl/tx_pkt_arbiter.sv
// Frame-atomic round-robin arbiter in front of the xge_mac pkt_tx_* port.
// Two packet sources share the interface. A grant is held from sop to eop,
// so frames never interleave. Per-source frame counters and sticky
// protocol-error flags are kept alongside.
//
// Ports
//   clk_156m25, reset_156m25   core clock, synchronous active-high reset
//   srcN_req                   source N has a frame ready (level)
//   srcN_data/val/sop/eop/mod  source N beat
//   srcN_gnt                   source N owns the interface
//   srcN_full                  source N must not assert val
//   pkt_tx_full                backpressure from xge_mac
//   pkt_tx_data/val/sop/eop/mod registered beat toward xge_mac (1-cycle latency)
//   clr_stats                  pulse: clears counters and error flags
//   frm_cnt0/1                 frames forwarded per source (wrapping)
//   proto_err                  sticky protocol-error flag, bit N = source N
module tx_pkt_arbiter
  import tx_arb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk_156m25,
  input  logic                  reset_156m25,

  input  logic                  src0_req,
  input  logic [PKT_DATA_W-1:0] src0_data,
  input  logic                  src0_val,
  input  logic                  src0_sop,
  input  logic                  src0_eop,
  input  logic [PKT_MOD_W-1:0]  src0_mod,
  output logic                  src0_gnt,
  output logic                  src0_full,

  input  logic                  src1_req,
  input  logic [PKT_DATA_W-1:0] src1_data,
  input  logic                  src1_val,
  input  logic                  src1_sop,
  input  logic                  src1_eop,
  input  logic [PKT_MOD_W-1:0]  src1_mod,
  output logic                  src1_gnt,
  output logic                  src1_full,

  input  logic                  pkt_tx_full,
  output logic [PKT_DATA_W-1:0] pkt_tx_data,
  output logic                  pkt_tx_val,
  output logic                  pkt_tx_sop,
  output logic                  pkt_tx_eop,
  output logic [PKT_MOD_W-1:0]  pkt_tx_mod,

  input  logic                  clr_stats,
  output logic [CNT_W-1:0]      frm_cnt0,
  output logic [CNT_W-1:0]      frm_cnt1,
  output logic [1:0]            proto_err
);

  // Round-robin pick among requesters; on a tie the source that was not
  // served last wins (last = 1 means source 1 was served last).
  function automatic arb_state_e rr_pick(input logic req0, input logic req1,
                                         input logic last);
    arb_state_e pick;
    if (req0 && req1) pick = last ? GNT0 : GNT1;
    else if (req0)    pick = GNT0;
    else if (req1)    pick = GNT1;
    else              pick = IDLE;
    return pick;
  endfunction

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       first_q, first_d;       // next accepted beat is the first of this grant
  logic [1:0] in_frame_q, in_frame_d;
  logic [1:0] err_q, err_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic                  tx_val_q, tx_val_d;
  logic                  tx_sop_q, tx_sop_d;
  logic                  tx_eop_q, tx_eop_d;
  logic [PKT_DATA_W-1:0] tx_data_q, tx_data_d;
  logic [PKT_MOD_W-1:0]  tx_mod_q, tx_mod_d;

  logic acc0, acc1, acc;
  logic sel_sop, sel_eop;
  logic [PKT_DATA_W-1:0] sel_data;
  logic [PKT_MOD_W-1:0]  sel_mod;
  logic bad0, bad1;

  // FSM: state register
  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // FSM: next state. At frame end the finishing source's own request is
  // ignored, so it can only be re-granted after passing through IDLE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: state_d = rr_pick(src0_req, src1_req, last_q);
      GNT0: if (acc0 && src0_eop) begin
        last_d  = 1'b0;
        state_d = src1_req ? GNT1 : IDLE;
      end
      GNT1: if (acc1 && src1_eop) begin
        last_d  = 1'b1;
        state_d = src0_req ? GNT0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    src0_gnt  = (state_q == GNT0);
    src1_gnt  = (state_q == GNT1);
    src0_full = ~src0_gnt | pkt_tx_full;
    src1_full = ~src1_gnt | pkt_tx_full;
  end

  // Beat acceptance, source mux, bookkeeping
  always_comb begin
    acc0     = src0_gnt & src0_val & ~pkt_tx_full;
    acc1     = src1_gnt & src1_val & ~pkt_tx_full;
    acc      = acc0 | acc1;
    sel_sop  = acc1 ? src1_sop  : src0_sop;
    sel_eop  = acc1 ? src1_eop  : src0_eop;
    sel_data = acc1 ? src1_data : src0_data;
    sel_mod  = acc1 ? src1_mod  : src0_mod;

    // A beat offered while full is dropped; a missing or repeated sop is
    // flagged but the beat still goes out.
    bad0 = (src0_val & src0_full) | (acc0 & first_q & ~src0_sop) |
           (acc0 & src0_sop & in_frame_q[0]);
    bad1 = (src1_val & src1_full) | (acc1 & first_q & ~src1_sop) |
           (acc1 & src1_sop & in_frame_q[1]);

    if (state_d != IDLE && state_d != state_q) first_d = 1'b1;
    else if (acc)                              first_d = 1'b0;
    else                                       first_d = first_q;

    in_frame_d = in_frame_q;
    if (acc0) in_frame_d[0] = src0_eop ? 1'b0 : (src0_sop | in_frame_q[0]);
    if (acc1) in_frame_d[1] = src1_eop ? 1'b0 : (src1_sop | in_frame_q[1]);

    if (clr_stats) begin
      err_d  = 2'b00;
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      err_d  = err_q | {bad1, bad0};
      cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, acc0 & src0_eop};
      cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, acc1 & src1_eop};
    end

    tx_val_d  = acc;
    tx_sop_d  = acc & sel_sop;
    tx_eop_d  = acc & sel_eop;
    tx_data_d = acc ? sel_data : tx_data_q;
    tx_mod_d  = acc ? sel_mod  : tx_mod_q;
  end

  // Output / stats register stage
  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      first_q    <= 1'b0;
      in_frame_q <= 2'b00;
      err_q      <= 2'b00;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      tx_val_q   <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_mod_q   <= '0;
    end else begin
      first_q    <= first_d;
      in_frame_q <= in_frame_d;
      err_q      <= err_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      tx_val_q   <= tx_val_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
      tx_data_q  <= tx_data_d;
      tx_mod_q   <= tx_mod_d;
    end
  end

  assign pkt_tx_val  = tx_val_q;
  assign pkt_tx_sop  = tx_sop_q;
  assign pkt_tx_eop  = tx_eop_q;
  assign pkt_tx_data = tx_data_q;
  assign pkt_tx_mod  = tx_mod_q;
  assign frm_cnt0    = cnt0_q;
  assign frm_cnt1    = cnt1_q;
  assign proto_err   = err_q;

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Bench for tx_pkt_arbiter: directed scenarios plus randomized rounds.
// Expected beats come from a frame-level round-robin model and are queued
// as a scoreboard; an independent monitor pops them as pkt_tx_val appears.
module tb_tx_pkt_arbiter;
  import tx_arb_pkg::*;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [PKT_DATA_W-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [PKT_MOD_W-1:0]  mod;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic src0_req, src0_val, src0_sop, src0_eop, src0_gnt, src0_full;
  logic src1_req, src1_val, src1_sop, src1_eop, src1_gnt, src1_full;
  logic [PKT_DATA_W-1:0] src0_data, src1_data, pkt_tx_data;
  logic [PKT_MOD_W-1:0]  src0_mod, src1_mod, pkt_tx_mod;
  logic pkt_tx_full, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, clr_stats;
  logic [CNT_W-1:0] frm_cnt0, frm_cnt1;
  logic [1:0] proto_err;

  tx_pkt_arbiter #(.CNT_W(CNT_W)) dut (
    .clk_156m25(clk), .reset_156m25(rst),
    .src0_req(src0_req), .src0_data(src0_data), .src0_val(src0_val),
    .src0_sop(src0_sop), .src0_eop(src0_eop), .src0_mod(src0_mod),
    .src0_gnt(src0_gnt), .src0_full(src0_full),
    .src1_req(src1_req), .src1_data(src1_data), .src1_val(src1_val),
    .src1_sop(src1_sop), .src1_eop(src1_eop), .src1_mod(src1_mod),
    .src1_gnt(src1_gnt), .src1_full(src1_full),
    .pkt_tx_full(pkt_tx_full), .pkt_tx_data(pkt_tx_data), .pkt_tx_val(pkt_tx_val),
    .pkt_tx_sop(pkt_tx_sop), .pkt_tx_eop(pkt_tx_eop), .pkt_tx_mod(pkt_tx_mod),
    .clr_stats(clr_stats), .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  beat_t sq0[$], sq1[$];     // beats each source still has to send
  beat_t mf0[$], mf1[$];     // same frames, consumed by the model
  beat_t exp_q[$];           // scoreboard
  logic [CNT_W-1:0] m_cnt0, m_cnt1;
  logic [1:0] exp_err;
  bit   m_last;
  int   first_out;

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every presented beat must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (pkt_tx_val === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {11'd0, pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, 80'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat", {11'd0, pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod},
                {11'd0, e.data, e.sop, e.eop, e.mod});
          if (first_out < 0) first_out = cyc;
        end
      end else if (rst === 1'b0) begin
        check("idle_sop_eop", {78'd0, pkt_tx_sop, pkt_tx_eop}, 80'd0);
      end
    end
  end

  task automatic gen_frame(input int s, input int len, input logic [2:0] lastmod, input bit nosop);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data        = {$urandom, $urandom};
      b.data[63:60] = (s == 0) ? 4'h0 : 4'h1;
      b.sop         = (i == 0) && !nosop;
      b.eop         = (i == len - 1);
      b.mod         = b.eop ? lastmod : 3'($urandom_range(0, 7));
      if (s == 0) begin sq0.push_back(b); mf0.push_back(b); end
      else        begin sq1.push_back(b); mf1.push_back(b); end
    end
    if (nosop) exp_err[s] = 1'b1;
  endtask

  // Frame-level model: while both have frames, alternate starting with the
  // source not served last; otherwise the only requester is served.
  task automatic build_expected();
    int pick;
    beat_t b;
    while (mf0.size() != 0 || mf1.size() != 0) begin
      if (mf0.size() != 0 && mf1.size() != 0) pick = m_last ? 0 : 1;
      else pick = (mf0.size() != 0) ? 0 : 1;
      do begin
        b = (pick == 0) ? mf0.pop_front() : mf1.pop_front();
        exp_q.push_back(b);
      end while (!b.eop);
      if (pick == 0) m_cnt0 = m_cnt0 + 1'b1; else m_cnt1 = m_cnt1 + 1'b1;
      m_last = (pick == 1);
    end
  endtask

  // Drives both sources until all queued frames are out. rnd adds random
  // backpressure and source stalls; fs/fl force a backpressure window;
  // strict checks first-output latency and absence of idle gaps.
  task automatic run_round(input bit rnd, input int fs, input int fl, input bit strict);
    int k = 0, gaps = 0, first_g = -1, start;
    bit v0p = 0, v1p = 0, fullp = 0, full, v0, v1, any;
    beat_t b;
    any = (sq0.size() != 0) || (sq1.size() != 0);
    build_expected();
    first_out = -1;
    start = cyc;
    forever begin
      if (v0p) b = sq0.pop_front();
      if (v1p) b = sq1.pop_front();
      if (sq0.size() == 0 && sq1.size() == 0 && exp_q.size() == 0) break;
      if (k > 3000) begin
        check("round_timeout", 80'(k), 80'd0);
        sq0.delete(); sq1.delete(); exp_q.delete();
        break;
      end
      full = (fl > 0 && k >= fs && k < fs + fl) || (rnd && $urandom_range(0, 99) < 15);
      pkt_tx_full = full;
      src0_req = (sq0.size() != 0);
      src1_req = (sq1.size() != 0);
      v0 = src0_gnt && !full && sq0.size() != 0 && !(rnd && $urandom_range(0, 99) < 20);
      v1 = src1_gnt && !full && sq1.size() != 0 && !(rnd && $urandom_range(0, 99) < 20);
      src0_val = v0;
      src1_val = v1;
      if (sq0.size() != 0) {src0_data, src0_sop, src0_eop, src0_mod} = sq0[0];
      if (sq1.size() != 0) {src1_data, src1_sop, src1_eop, src1_mod} = sq1[0];
      if (first_g < 0 && (src0_gnt || src1_gnt)) first_g = k;
      if (first_g >= 0 && !src0_gnt && !src1_gnt && (sq0.size() != 0 || sq1.size() != 0)) gaps++;
      #1;
      check("src0_full", 80'(src0_full), 80'(!src0_gnt || full));
      check("src1_full", 80'(src1_full), 80'(!src1_gnt || full));
      if (fullp) check("val_after_full", 80'(pkt_tx_val), 80'd0);
      if (fl > 0 && k >= fs && k < fs + fl) check("gnt_held_full", 80'(src0_gnt), 80'd1);
      v0p = v0; v1p = v1; fullp = full;
      k++;
      @(negedge clk);
    end
    src0_req = 0; src1_req = 0; src0_val = 0; src1_val = 0; pkt_tx_full = 0;
    @(negedge clk);
    check("frm_cnt0", 80'(frm_cnt0), 80'(m_cnt0));
    check("frm_cnt1", 80'(frm_cnt1), 80'(m_cnt1));
    check("proto_err", 80'(proto_err), 80'(exp_err));
    check("gnt_released", {78'd0, src0_gnt, src1_gnt}, 80'd0);
    if (any) check("gnt_latency", 80'(first_g), 80'd1);
    if (strict) begin
      check("out_latency", 80'(first_out - start), 80'd2);
      check("idle_gaps", 80'(gaps), 80'd0);
    end
  endtask

  task automatic do_clr();
    clr_stats = 1;
    @(negedge clk);
    clr_stats = 0;
    m_cnt0 = '0; m_cnt1 = '0; exp_err = 2'b00;
    @(negedge clk);
    check("clr_proto_err", 80'(proto_err), 80'd0);
    check("clr_frm_cnt", {72'd0, frm_cnt0, frm_cnt1}, 80'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; clr_stats = 0; pkt_tx_full = 0;
    src0_req = 0; src0_val = 0; src0_sop = 0; src0_eop = 0; src0_mod = 0; src0_data = 0;
    src1_req = 0; src1_val = 0; src1_sop = 0; src1_eop = 0; src1_mod = 0; src1_data = 0;
    m_cnt0 = '0; m_cnt1 = '0; exp_err = 2'b00; m_last = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Reset state
    check("rst_gnt", {78'd0, src0_gnt, src1_gnt}, 80'd0);
    check("rst_full", {78'd0, src0_full, src1_full}, 80'h3);
    check("rst_val_sop_eop", {77'd0, pkt_tx_val, pkt_tx_sop, pkt_tx_eop}, 80'd0);
    check("rst_data", 80'(pkt_tx_data), 80'd0);
    check("rst_mod", 80'(pkt_tx_mod), 80'd0);
    check("rst_cnt", {72'd0, frm_cnt0, frm_cnt1}, 80'd0);
    check("rst_err", 80'(proto_err), 80'd0);

    // Both requesting from reset, two frames each: order 0,1,0,1, no gaps
    gen_frame(0, 3, 3'd2, 0); gen_frame(0, 2, 3'd7, 0);
    gen_frame(1, 2, 3'd1, 0); gen_frame(1, 4, 3'd0, 0);
    run_round(0, 0, 0, 1);

    // Single source, 3-beat frame ending with mod=5
    gen_frame(0, 3, 3'd5, 0);
    run_round(0, 0, 0, 1);

    // Backpressure for 4 cycles mid-frame
    gen_frame(0, 6, 3'd3, 0);
    run_round(0, 3, 4, 0);

    // Source 1 offers a beat without a grant: dropped and flagged
    src1_val = 1; src1_sop = 1; src1_eop = 1; src1_mod = 3'd4;
    src1_data = 64'hDEAD_BEEF_0BAD_F00D;
    @(negedge clk);
    src1_val = 0; src1_sop = 0; src1_eop = 0;
    @(negedge clk);
    check("err_ungranted_val", 80'(proto_err), 80'h2);
    check("err_no_count", {72'd0, frm_cnt0, frm_cnt1}, {72'd0, m_cnt0, m_cnt1});
    do_clr();

    // Single-beat frame, mod=0
    gen_frame(1, 1, 3'd0, 0);
    run_round(0, 0, 0, 1);

    // First beat of a grant without sop: forwarded but flagged
    gen_frame(0, 2, 3'd6, 1);
    run_round(0, 0, 0, 0);
    do_clr();

    // Counter wrap: 15 frames, then one more
    for (int i = 0; i < 15; i++) gen_frame(0, 1, 3'($urandom_range(0, 7)), 0);
    run_round(0, 0, 0, 0);
    gen_frame(0, 1, 3'd1, 0);
    run_round(0, 0, 0, 0);

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      for (int i = 0; i < n0; i++) gen_frame(0, $urandom_range(1, 5), 3'($urandom_range(0, 7)), 0);
      for (int i = 0; i < n1; i++) gen_frame(1, $urandom_range(1, 5), 3'($urandom_range(0, 7)), 0);
      run_round(1, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_pkt_arbiter.md
Name: tx_pkt_arbiter

Overview:
- Frame-atomic round-robin arbiter that shares the xge_mac packet transmit interface (pkt_tx_*) between two packet sources, e.g. the host path and a pause/management frame generator.
- Sits in the 156.25 MHz core clock domain, directly upstream of xge_mac.
- A grant is held from sop to eop so frames never interleave.
- Also keeps per-source frame counters and sticky protocol-error flags.

Parameters:
- CNT_W, 16, width of each per-source frame counter; counters wrap modulo 2^CNT_W.

Ports:
- clk_156m25  in  1  core clock; the block's only clock.
- reset_156m25  in  1  synchronous, active-high reset.
- src0_req  in  1  level; source 0 has a frame ready.
- src0_data  in  64  source 0 beat data.
- src0_val  in  1  source 0 beat valid.
- src0_sop  in  1  source 0 start of frame.
- src0_eop  in  1  source 0 end of frame.
- src0_mod  in  3  source 0 valid bytes on the eop beat (0 = all 8).
- src0_gnt  out  1  source 0 currently owns the interface.
- src0_full  out  1  source 0 must not assert val.
- src1_*  same set as src0_*, for source 1.
- pkt_tx_full  in  1  backpressure from xge_mac.
- pkt_tx_data  out  64  to xge_mac.
- pkt_tx_val  out  1  to xge_mac.
- pkt_tx_sop  out  1  to xge_mac.
- pkt_tx_eop  out  1  to xge_mac.
- pkt_tx_mod  out  3  to xge_mac.
- clr_stats  in  1  one-cycle pulse; clears counters and error flags.
- frm_cnt0  out  CNT_W  frames forwarded from source 0.
- frm_cnt1  out  CNT_W  frames forwarded from source 1.
- proto_err  out  2  sticky protocol-error flag per source, bit n = source n.

Behaviour:
- Reset: the following are all 0: state IDLE, last_served=1 (source 0 wins the first tie), src*_gnt, pkt_tx_val/sop/eop, pkt_tx_data, pkt_tx_mod, frm_cnt*, proto_err.
- States: IDLE, GNT0, GNT1.
- IDLE: if exactly one srcN_req is high, go to GNTN. If both are high, grant the source that is not last_served. Otherwise stay in IDLE.
- srcN_gnt = (state==GNTN), registered.
- srcN_full = ~srcN_gnt | pkt_tx_full, combinational.
- Accepted beat for source N: srcN_gnt & srcN_val & ~pkt_tx_full.
- Output pipeline: on an accepted beat, pkt_tx_* is registered from srcN_* with pkt_tx_val=1. In every other cycle pkt_tx_val/sop/eop = 0 and data/mod hold their previous values. Latency is exactly 1 cycle. xge_mac full-threshold slack absorbs the in-flight beat.
- Frame end: an accepted beat with eop set ends the grant and sets last_served=N.
  - In the same cycle, requests are re-evaluated as in IDLE, excluding the srcN_req that is being sampled (the other source is preferred).
  - If the other source is requesting, go directly to its grant with no idle cycle. Otherwise go to IDLE.
  - The next state is never GNTN again without passing through IDLE.
- In-frame flag per source:
  - Set on an accepted sop.
  - Cleared on an accepted eop.
  - A beat carrying both sop and eop is a single-beat frame.
- Counters: frm_cntN increments on each accepted eop beat from source N and wraps to 0 after 2^CNT_W-1.
- Protocol errors: proto_err[N] is set sticky on any of these:
  - srcN_val while srcN_full=1; the beat is dropped and not forwarded.
  - First accepted beat of a grant without sop; the beat is still forwarded.
  - sop while in-frame; the beat is still forwarded.
- Grant persistence: pkt_tx_full held high, or srcN_val low mid-frame, keeps the grant indefinitely; no timeout.
- clr_stats clears frm_cnt* and proto_err. If an increment and clr_stats coincide, the clear wins.
- Reset mid-frame: all state is dropped, with no eop generated toward xge_mac. Upstream reset is required to coincide.

Decomposition:
- Package tx_arb_pkg holds the following, shared with the bench:
  - typedef arb_state_e {IDLE, GNT0, GNT1}.
  - Constants PKT_DATA_W=64 and PKT_MOD_W=3.
- No sub-module is needed. The round-robin pick is a small function inside the module.

Test Plan:
- Only src0_req=1, 3-beat frame, pkt_tx_full=0:
  - src0_gnt rises 1 cycle after req.
  - pkt_tx_* mirrors the beats 1 cycle later: sop on beat 1, eop with mod=5 on beat 3.
  - frm_cnt0=1, then state returns to IDLE.
- Both req high from reset, each source sends 2 frames back-to-back:
  - Grant order is 0,1,0,1.
  - No IDLE cycle between frames.
  - frm_cnt0=frm_cnt1=2.
- pkt_tx_full asserted mid-frame for 4 cycles:
  - src0_full=1 for those 4 cycles and no pkt_tx_val is issued.
  - The frame then resumes and completes intact, in order.
- src1 asserts val while not granted:
  - proto_err=2'b10.
  - The beat does not appear on pkt_tx_*.
  - clr_stats then returns proto_err to 0.
- Single-beat frame (sop=eop=1, mod=0):
  - Forwarded with sop=eop=1.
  - frm_cnt increments and the grant releases after that one beat.
- frm_cnt preloaded to 0xFFFF via 65535 frames (or CNT_W=4 build with 15 frames), then one more frame: counter wraps to 0.
